alu_ex_stage: RTL and testbench
===============================

// Module: alu_ex_stage
// PURPOSE
//   Execute-stage ALU wrapper that sits directly upstream of adder_ks. It decodes the
//   ALU op, forms the adder operands (B inverted and carry-in forced for subtract and
//   compare), and derives logic, compare and branch flags from the adder outputs.
//   Results are registered behind a valid/ready handshake with a 1-entry skid buffer,
//   so the writeback/branch stage can stall without a combinational ready path.
// PARAMETERS
//   WIDTH   32  datapath width; adder_ks is instantiated at 32, so only 32 is legal
//   TAG_W   5   sideband tag width (rd index), passed through unchanged
// PORTS
//   i_clk      in   1       clock, rising edge
//   i_reset_n  in   1       asynchronous active-low reset
//   i_flush    in   1       synchronous kill of all held results
//   i_valid    in   1       upstream operation valid
//   o_ready    out  1       stage can accept an operation this cycle
//   i_op       in   3       alu_op_t (see STRUCTURE)
//   i_a        in   WIDTH   operand A (rs1)
//   i_b        in   WIDTH   operand B (rs2/imm)
//   i_tag      in   TAG_W   sideband tag
//   o_valid    out  1       result valid
//   i_ready    in   1       downstream accepts the result
//   o_result   out  WIDTH   ALU result
//   o_tag      out  TAG_W   tag of the result
//   o_eq       out  1       i_a == i_b
//   o_lt       out  1       signed i_a < i_b
//   o_ltu      out  1       unsigned i_a < i_b
// BEHAVIOUR
//   - Reset (async assert, sync release): o_valid=0; skid empty; o_result, o_tag and
//     all flags are 0. o_ready=1 on the first cycle after reset release.
//   - Adder inputs: for SUB/SLT/SLTU, b_eff = ~i_b and c_in = 1; for all other ops,
//     b_eff = i_b and c_in = 0.
//   - Ops:
//       ADD=0  sum
//       SUB=1  sum
//       AND=2  o_and from the adder
//       OR=3   o_and | o_xor
//       XOR=4  o_xor
//       SLT=5  {31'b0, lt}
//       SLTU=6 {31'b0, ltu}
//       PASSB=7 i_b
//   - Flags, always computed with c_in=1 and ~i_b for every op, using a second
//     comparison path or the same adder when the op already subtracts:
//       eq  = (i_a ^ i_b) == 0
//       ltu = ~carry_out
//       lt  = (i_a[31] ^ i_b[31]) ? i_a[31] : sum[31]
//   - Wrap-around: results are modulo 2^32. 0xFFFFFFFF+1 = 0; 0-1 = 0xFFFFFFFF.
//     No overflow flag is produced.
//   - Latency: 1 cycle, input accepted in cycle N, o_valid in N+1. Throughput is
//     1 op/cycle while i_ready=1.
//   - Handshake:
//       transfer in when i_valid & o_ready; transfer out when o_valid & i_ready.
//       o_valid stays high, and o_result/o_tag/flags stay stable, until accepted.
//       o_ready = ~skid_full (registered).
//   - Skid buffer:
//       accept while the output reg is full and i_ready=0 -> write to skid,
//       skid_full=1.
//       output accepted while skid full -> skid moves to output, skid_full=0,
//       o_ready=1 next cycle.
//       Accept-in and accept-out in the same cycle with skid empty -> output reg
//       is overwritten by the new op.
//   - i_flush: o_valid=0 and skid_full=0 next cycle. An input offered in the same
//     cycle is dropped. Flush has priority over every other event.
//   - Reset mid-operation discards all held results immediately (asynchronous).
//   - Illegal ops: none, since all 8 encodings are defined.
// STRUCTURE
//   - alu_pkg: typedef enum logic [2:0] alu_op_t {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
//     ALU_XOR, ALU_SLT, ALU_SLTU, ALU_PASSB}; localparam XLEN = 32; a packed struct
//     alu_res_t {result, tag, eq, lt, ltu} used for both the output and skid regs.
//   - Sub-modules: one adder_ks instance for the result path; the compare path is a
//     second adder_ks instance (u_cmp) with ~i_b and c_in=1.
//   - Output and skid registers are alu_res_t.
// TESTING
//   1. Reset held, then released -> o_valid=0, o_ready=1, o_result=0, o_tag=0.
//   2. ADD 0xFFFFFFFF+0x1, tag 3, i_ready=1 -> next cycle o_result=0, o_tag=3,
//      o_ltu=0, o_valid=1 for 1 cycle.
//   3. SUB 0x0-0x1 -> 0xFFFFFFFF with lt=1, ltu=1, eq=0. SLT 0x80000000 vs 0x1 -> 1.
//      SLTU with the same operands -> 0.
//   4. Back-to-back ops A, B, C with i_ready=0 from cycle 1 -> A held on output, B in
//      skid, o_ready=0, C not accepted. Raise i_ready -> A, B, C delivered in order,
//      no loss or duplication.
//   5. i_flush while output and skid are full and i_valid=1 -> next cycle o_valid=0,
//      o_ready=1, and the dropped op never appears.
//   6. Random ops/operands with random i_valid/i_ready against a reference model over
//      10k ops. Also assert i_reset_n low mid-stream -> o_valid drops with no clock.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: op encoding, result record and
// the decode helper that selects the subtract-class operand path.
package alu_pkg;

    localparam int XLEN      = 32;
    localparam int ALU_TAG_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_SLT   = 3'd5,
        ALU_SLTU  = 3'd6,
        ALU_PASSB = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic [XLEN-1:0]      result;
        logic [ALU_TAG_W-1:0] tag;
        logic                 eq;
        logic                 lt;
        logic                 ltu;
    } alu_res_t;

    function automatic logic op_subtracts(input alu_op_t op);
        logic sub;
        case (op)
            ALU_SUB, ALU_SLT, ALU_SLTU: sub = 1'b1;
            default:                    sub = 1'b0;
        endcase
        return sub;
    endfunction

endpackage

// File: rtl/adder_ks.sv
// Kogge-Stone parallel-prefix adder; also exposes the raw bitwise AND/XOR
// terms so the ALU can reuse them for its logic ops.
module adder_ks #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c,
    output logic [WIDTH-1:0] o_and,
    output logic [WIDTH-1:0] o_xor
);

    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] g_nxt_s;
    logic [WIDTH-1:0] p_nxt_s;

    assign o_and = i_a & i_b;
    assign o_xor = i_a ^ i_b;

    // Prefix tree; the carry-in is folded into the bit-0 generate term
    always_comb begin
        g_s     = i_a & i_b;
        p_s     = i_a ^ i_b;
        g_s[0]  = g_s[0] | (p_s[0] & i_c);
        g_nxt_s = g_s;
        p_nxt_s = p_s;
        for (int k = 0; k < LEVELS; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (32'sd1 <<< k)) begin
                    g_nxt_s[i] = g_s[i] | (p_s[i] & g_s[i - (32'sd1 <<< k)]);
                    p_nxt_s[i] = p_s[i] & p_s[i - (32'sd1 <<< k)];
                end else begin
                    g_nxt_s[i] = g_s[i];
                    p_nxt_s[i] = p_s[i];
                end
            end
            g_s = g_nxt_s;
            p_s = p_nxt_s;
        end
    end

    assign o_sum = o_xor ^ {g_s[WIDTH-2:0], i_c};
    assign o_c   = g_s[WIDTH-1];

endmodule

// File: rtl/alu_ex_stage.sv
// Execute-stage ALU: op decode around a result adder and a compare adder,
// with a registered valid/ready output stage backed by a 1-entry skid buffer.
module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int TAG_W = ALU_TAG_W
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  alu_op_t          i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_eq,
    output logic             o_lt,
    output logic             o_ltu
);

    logic             sub_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] add_sum_s;
    logic [WIDTH-1:0] add_and_s;
    logic [WIDTH-1:0] add_xor_s;
    logic             unused_add_cout_s;
    logic [WIDTH-1:0] cmp_sum_s;
    logic [WIDTH-1:0] cmp_xor_s;
    logic [WIDTH-1:0] unused_cmp_and_s;
    logic             cmp_cout_s;
    logic             eq_s;
    logic             lt_s;
    logic             ltu_s;
    logic             in_fire_s;
    logic             out_free_s;
    alu_res_t         new_s;
    alu_res_t         out_r;
    alu_res_t         skid_r;
    logic             out_valid_r;
    logic             skid_full_r;

    assign sub_s   = op_subtracts(i_op);
    assign b_eff_s = sub_s ? ~i_b : i_b;

    adder_ks #(.WIDTH(WIDTH)) u_add (
        .i_a   (i_a),
        .i_b   (b_eff_s),
        .i_c   (sub_s),
        .o_sum (add_sum_s),
        .o_c   (unused_add_cout_s),
        .o_and (add_and_s),
        .o_xor (add_xor_s)
    );

    // Compare path always evaluates a - b so flags are valid for every op
    adder_ks #(.WIDTH(WIDTH)) u_cmp (
        .i_a   (i_a),
        .i_b   (~i_b),
        .i_c   (1'b1),
        .o_sum (cmp_sum_s),
        .o_c   (cmp_cout_s),
        .o_and (unused_cmp_and_s),
        .o_xor (cmp_xor_s)
    );

    // a ^ ~b is all ones exactly when a == b
    assign eq_s  = &cmp_xor_s;
    assign ltu_s = ~cmp_cout_s;
    assign lt_s  = (i_a[WIDTH-1] ^ i_b[WIDTH-1]) ? i_a[WIDTH-1] : cmp_sum_s[WIDTH-1];

    // Result mux and packing of the record that enters the output stage
    always_comb begin
        new_s     = '0;
        new_s.tag = i_tag;
        new_s.eq  = eq_s;
        new_s.lt  = lt_s;
        new_s.ltu = ltu_s;
        case (i_op)
            ALU_ADD, ALU_SUB: new_s.result = add_sum_s;
            ALU_AND:          new_s.result = add_and_s;
            ALU_OR:           new_s.result = add_and_s | add_xor_s;
            ALU_XOR:          new_s.result = add_xor_s;
            ALU_SLT:          new_s.result = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU:         new_s.result = {{(WIDTH-1){1'b0}}, ltu_s};
            ALU_PASSB:        new_s.result = i_b;
            default:          new_s.result = '0;
        endcase
    end

    assign in_fire_s  = i_valid & ~skid_full_r & ~i_flush;
    assign out_free_s = ~out_valid_r | i_ready;

    // Output register and skid buffer; flush outranks every other event
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            out_r       <= '0;
            skid_r      <= '0;
            out_valid_r <= 1'b0;
            skid_full_r <= 1'b0;
        end else if (i_flush) begin
            out_valid_r <= 1'b0;
            skid_full_r <= 1'b0;
        end else if (out_free_s) begin
            if (skid_full_r) begin
                out_r       <= skid_r;
                out_valid_r <= 1'b1;
                skid_full_r <= 1'b0;
            end else if (in_fire_s) begin
                out_r       <= new_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (in_fire_s) begin
            skid_r      <= new_s;
            skid_full_r <= 1'b1;
        end else begin
            skid_full_r <= skid_full_r;
        end
    end

    assign o_ready  = ~skid_full_r;
    assign o_valid  = out_valid_r;
    assign o_result = out_r.result;
    assign o_tag    = out_r.tag;
    assign o_eq     = out_r.eq;
    assign o_lt     = out_r.lt;
    assign o_ltu    = out_r.ltu;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Scoreboard bench for alu_ex_stage: expected records are queued on input
// transfer and popped on output transfer.
module tb_alu_ex_stage;
    import alu_pkg::*;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    alu_op_t     i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [4:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [4:0]  o_tag;
    logic        o_eq;
    logic        o_lt;
    logic        o_ltu;

    alu_res_t q[$];
    int       n_cmp = 0;
    int       n_err = 0;

    alu_ex_stage dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_flush   (i_flush),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op      (i_op),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_tag     (i_tag),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
        .o_tag     (o_tag),
        .o_eq      (o_eq),
        .o_lt      (o_lt),
        .o_ltu     (o_ltu)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic alu_res_t model(alu_op_t op, logic [31:0] a, logic [31:0] b, logic [4:0] tag);
        alu_res_t r;
        r.tag = tag;
        r.eq  = (a == b);
        r.lt  = ($signed(a) < $signed(b));
        r.ltu = (a < b);
        case (op)
            ALU_ADD:   r.result = a + b;
            ALU_SUB:   r.result = a - b;
            ALU_AND:   r.result = a & b;
            ALU_OR:    r.result = a | b;
            ALU_XOR:   r.result = a ^ b;
            ALU_SLT:   r.result = {31'd0, r.lt};
            ALU_SLTU:  r.result = {31'd0, r.ltu};
            default:   r.result = b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = 32'h0000_0001;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // One clock: sample outputs, update the scoreboard, advance to the next negedge.
    task automatic step(output logic fired, output logic took, output alu_res_t obs, output alu_res_t exp);
        took  = i_valid && o_ready && !i_flush;
        fired = o_valid && i_ready;
        obs   = {o_result, o_tag, o_eq, o_lt, o_ltu};
        exp   = ~obs;
        if (fired && q.size() != 0) exp = q.pop_front();
        if (i_flush) q.delete();
        if (took) q.push_back(model(i_op, i_a, i_b, i_tag));
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_op = ALU_ADD; i_a = 32'd0; i_b = 32'd0; i_tag = 5'd0;
        repeat (3) @(negedge i_clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_hold_valid: got %b want 0", o_valid); end
        i_reset_n = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        n_cmp++; if (o_result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", o_result); end
        n_cmp++; if (o_tag !== 5'd0) begin n_err++; $display("FAIL reset_tag: got %h want 0", o_tag); end
        n_cmp++; if ({o_eq, o_lt, o_ltu} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {o_eq, o_lt, o_ltu}); end
    endtask

    task automatic test_add_wrap();
        logic f, t;
        alu_res_t obs, exp;
        i_ready = 1'b1; i_valid = 1'b1; i_op = ALU_ADD;
        i_a = 32'hFFFF_FFFF; i_b = 32'h0000_0001; i_tag = 5'd3;
        step(f, t, obs, exp);
        i_valid = 1'b0;
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL add_latency: o_valid got %b want 1", o_valid); end
        step(f, t, obs, exp);
        n_cmp++; if (obs.result !== 32'd0 || obs.tag !== 5'd3 || obs.ltu !== 1'b0)
            begin n_err++; $display("FAIL add_wrap: got res=%h tag=%0d ltu=%b want res=0 tag=3 ltu=0", obs.result, obs.tag, obs.ltu); end
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL add_sb: got %h want %h", obs, exp); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL add_one_cycle: o_valid got %b want 0", o_valid); end
    endtask

    task automatic test_sub_slt();
        logic f, t;
        alu_res_t obs, exp;
        alu_op_t     ops [3] = '{ALU_SUB, ALU_SLT, ALU_SLTU};
        logic [31:0] as  [3] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
        logic [31:0] want[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        int k = 0;
        i_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            i_valid = (c < 3);
            if (c < 3) begin i_op = ops[c]; i_a = as[c]; i_b = bs[c]; i_tag = 5'(c + 1); end
            step(f, t, obs, exp);
            if (f) begin
                n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL sub_slt_sb: got %h want %h", obs, exp); end
                if (k < 3) begin
                    n_cmp++; if (obs.result !== want[k]) begin n_err++; $display("FAIL sub_slt_res%0d: got %h want %h", k, obs.result, want[k]); end
                end
                if (k == 0) begin
                    n_cmp++; if ({obs.eq, obs.lt, obs.ltu} !== 3'b011) begin n_err++; $display("FAIL sub_flags: got %b want 011", {obs.eq, obs.lt, obs.ltu}); end
                end
                k++;
            end
        end
        n_cmp++; if (k != 3) begin n_err++; $display("FAIL sub_slt_count: got %0d want 3", k); end
    endtask

    task automatic test_back_to_back();
        logic f, t;
        alu_res_t obs, exp;
        alu_op_t     ops [3] = '{ALU_ADD, ALU_XOR, ALU_OR};
        logic [31:0] as  [3] = '{32'd5, 32'hA5A5_A5A5, 32'h1234_0000};
        logic [31:0] bs  [3] = '{32'd7, 32'hFFFF_0000, 32'h0000_5678};
        logic [4:0]  tags[3] = '{5'd10, 5'd11, 5'd12};
        int k = 0;
        int sent = 0;
        i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_valid = 1'b1; i_op = ops[c]; i_a = as[c]; i_b = bs[c]; i_tag = tags[c];
            step(f, t, obs, exp);
            if (t) sent++;
        end
        n_cmp++; if (sent != 2) begin n_err++; $display("FAIL b2b_accepted: got %0d want 2", sent); end
        n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready: got %b want 0", o_ready); end
        n_cmp++; if (o_valid !== 1'b1 || o_result !== 32'd12 || o_tag !== 5'd10)
            begin n_err++; $display("FAIL b2b_hold: got v=%b res=%h tag=%0d want v=1 res=c tag=10", o_valid, o_result, o_tag); end
        i_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(f, t, obs, exp);
            if (t) begin sent++; i_valid = 1'b0; end
            if (f) begin
                n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL b2b_sb: got %h want %h", obs, exp); end
                if (k < 3) begin
                    n_cmp++; if (obs.tag !== tags[k]) begin n_err++; $display("FAIL b2b_order: got %0d want %0d", obs.tag, tags[k]); end
                end
                k++;
            end
        end
        i_valid = 1'b0;
        n_cmp++; if (k != 3 || q.size() != 0) begin n_err++; $display("FAIL b2b_count: got %0d delivered, %0d left want 3, 0", k, q.size()); end
    endtask

    task automatic test_flush();
        logic f, t;
        alu_res_t obs, exp;
        i_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            i_valid = 1'b1; i_op = ALU_PASSB; i_a = 32'd0; i_b = 32'(c + 100); i_tag = 5'(c + 20);
            step(f, t, obs, exp);
        end
        i_flush = 1'b1; i_b = 32'hDEAD_BEEF; i_tag = 5'd30;
        step(f, t, obs, exp);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", o_ready); end
        i_b = 32'hCAFE_F00D; i_tag = 5'd31;
        step(f, t, obs, exp);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop_empty: o_valid got %b want 0", o_valid); end
        i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(f, t, obs, exp);
            n_cmp++; if (f) begin n_err++; $display("FAIL flush_ghost: got tag %0d res %h want no output", obs.tag, obs.result); end
        end
    endtask

    task automatic test_random();
        logic f, t;
        alu_res_t obs, exp;
        int accepted = 0;
        int cycles = 0;
        logic did_reset = 1'b0;
        while (accepted < 10000 && cycles < 60000) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 9) < 7);
            i_flush = ($urandom_range(0, 199) == 0);
            i_op    = alu_op_t'($urandom_range(0, 7));
            i_a     = pick_operand();
            i_b     = ($urandom_range(0, 7) == 0) ? i_a : pick_operand();
            i_tag   = 5'($urandom);
            step(f, t, obs, exp);
            cycles++;
            if (t) accepted++;
            if (f) begin
                n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rand_sb: got %h want %h", obs, exp); end
            end
            n_cmp++; if (o_valid !== (q.size() != 0)) begin n_err++; $display("FAIL rand_valid: got %b want %b", o_valid, q.size() != 0); end
            n_cmp++; if (o_ready !== (q.size() < 2)) begin n_err++; $display("FAIL rand_ready: got %b want %b", o_ready, q.size() < 2); end
            if (!did_reset && accepted >= 5000 && o_valid) begin
                did_reset = 1'b1;
                #2 i_reset_n = 1'b0;
                #1;
                n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL async_reset: o_valid got %b want 0", o_valid); end
                q.delete();
                @(negedge i_clk);
                i_reset_n = 1'b1;
                n_cmp++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin n_err++; $display("FAIL post_reset: got v=%b r=%b want v=0 r=1", o_valid, o_ready); end
            end
        end
        n_cmp++; if (accepted < 10000 || !did_reset) begin n_err++; $display("FAIL rand_budget: got %0d ops reset=%b want 10000 ops reset=1", accepted, did_reset); end
        i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(f, t, obs, exp);
            if (f) begin
                n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rand_drain: got %h want %h", obs, exp); end
            end
        end
        n_cmp++; if (q.size() != 0 || o_valid !== 1'b0) begin n_err++; $display("FAIL rand_empty: got %0d left v=%b want 0 left v=0", q.size(), o_valid); end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_slt();
        test_back_to_back();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
